csr_counter_bank: RTL

- Parametrised bank of NUM_COUNTERS free-running CSR counters, each COUNTER_W bits wide (33-64), replacing the fixed cycle/instret counter logic in the CSR unit.
- Each counter advances by a per-cycle increment of up to 2^INC_W-1, so instret can take one increment per commit port.
- Provides a per-counter inhibit (mcountinhibit-style), 32-bit CSR-width low/high half read and write, a sticky wrap flag, and a registered read path.

---
 rtl/csr_counter_bank.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/csr_counter_bank.sv
// Bank of free-running CSR counters with inhibit, 32-bit half read/write, sticky wrap and registered read.
// Optional build macro CSR_COUNTER_SNAPSHOT_EN: a low-half read latches the upper half for a consistent high-half read.
module csr_counter_bank #(
    parameter int NUM_COUNTERS = 3,
    parameter int COUNTER_W    = 33,
    parameter int INC_W        = 2,
    localparam int SEL_W       = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_COUNTERS*INC_W-1:0] inc,
    input  logic [NUM_COUNTERS-1:0]       inhibit,
    input  logic                          rd_en,
    input  logic [SEL_W-1:0]              rd_sel,
    input  logic                          rd_hi,
    output logic                          rd_valid,
    output logic [31:0]                   rd_data,
    input  logic                          wr_en,
    input  logic [SEL_W-1:0]              wr_sel,
    input  logic                          wr_hi,
    input  logic [31:0]                   wr_data,
    output logic [NUM_COUNTERS-1:0]       wrapped
);

    localparam int HI_W = COUNTER_W - 32;

    if (COUNTER_W < 33 || COUNTER_W > 64 || NUM_COUNTERS < 1) begin : g_bad_params
        $error("csr_counter_bank: COUNTER_W must be 33..64 and NUM_COUNTERS >= 1");
    end

    if (HI_W < 32) begin : g_wr_data_unused
        logic unused_wr_data_hi;
        assign unused_wr_data_hi = &{1'b0, wr_data[31:HI_W]};
    end

    logic [COUNTER_W-1:0]  cnt_q   [NUM_COUNTERS];
    logic [COUNTER_W-1:0]  cnt_d   [NUM_COUNTERS];
    logic [COUNTER_W:0]    inc_sum [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] wrap_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i]   = cnt_q[i];
            wrap_d[i]  = wrapped[i];
            inc_sum[i] = {1'b0, cnt_q[i]} + (COUNTER_W+1)'(inc[i*INC_W +: INC_W]);
            if (wr_en && (wr_sel == SEL_W'(i))) begin
                // A write replaces this cycle's increment outright and restarts wrap tracking.
                if (wr_hi) begin
                    cnt_d[i][COUNTER_W-1:32] = wr_data[HI_W-1:0];
                end else begin
                    cnt_d[i][31:0] = wr_data;
                end
                wrap_d[i] = 1'b0;
            end else if (!inhibit[i]) begin
                cnt_d[i] = inc_sum[i][COUNTER_W-1:0];
                if (inc_sum[i][COUNTER_W]) begin
                    wrap_d[i] = 1'b1;
                end
            end
        end
    end

    // NOTE: the counter array is architectural state, so every entry is cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
            end
            wrapped <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wrapped <= wrap_d;
        end
    end

    logic [COUNTER_W-1:0] sel_cnt;
    logic                 sel_ok;
    logic [HI_W-1:0]      live_hi;
    logic [HI_W-1:0]      hi_word;
    logic [31:0]          rd_word;

`ifdef CSR_COUNTER_SNAPSHOT_EN
    logic [HI_W-1:0]  snap_val;
    logic [SEL_W-1:0] snap_sel;
    logic             snap_ok;
`endif

    always_comb begin
        sel_cnt = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_cnt = cnt_q[i];
                sel_ok  = 1'b1;
            end
        end
        live_hi = sel_cnt[COUNTER_W-1:32];
        hi_word = live_hi;
`ifdef CSR_COUNTER_SNAPSHOT_EN
        if (snap_ok && (snap_sel == rd_sel)) begin
            hi_word = snap_val;
        end
`endif
        if (!sel_ok) begin
            rd_word = '0;
        end else if (rd_hi) begin
            rd_word = 32'(hi_word);
        end else begin
            rd_word = sel_cnt[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

`ifdef CSR_COUNTER_SNAPSHOT_EN
    // A write landing on the tagged counter makes the captured upper half stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_val <= '0;
            snap_sel <= '0;
            snap_ok  <= 1'b0;
        end else if (rd_en && !rd_hi && sel_ok) begin
            snap_val <= live_hi;
            snap_sel <= rd_sel;
            snap_ok  <= !(wr_en && (wr_sel == rd_sel));
        end else if (wr_en && (wr_sel == snap_sel)) begin
            snap_ok <= 1'b0;
        end
    end
`endif

endmodule
